ramsim_dpi: RTL and testbench

- Cycle-accurate behavioural RAM model with independent read and write channels.
- Each channel accepts one request at a time through a valid/ready handshake. It completes the request after a fixed latency and signals completion with a one-cycle finish pulse.
- Used as the memory endpoint behind cache/LSU logic in block and system simulation.

---
 rtl/ramsim_dpi_if.sv | 28 ++
 rtl/ramsim_dpi.sv | 163 ++++++++++++++++
 tb/tb_ramsim_dpi.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ramsim_dpi_if.sv
// ramsim_dpi_if: request/response bundle between a memory client and the ramsim_dpi RAM model.
//   rvalid/raddr          read request (client -> RAM)
//   wvalid/waddr/wdata    write request (client -> RAM)
//   readReady/writeReady  channel idle, next request can be accepted (RAM -> client)
//   readfin/rdata         one-cycle read-complete pulse and read data (RAM -> client)
//   writefin              one-cycle write-committed pulse (RAM -> client)
interface ramsim_dpi_if;
    logic        rvalid;
    logic        wvalid;
    logic [63:0] raddr;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic        readfin;
    logic        writefin;
    logic        readReady;
    logic        writeReady;
    logic [63:0] rdata;

    modport master (
        output rvalid, wvalid, raddr, waddr, wdata,
        input  readfin, writefin, readReady, writeReady, rdata
    );

    modport slave (
        input  rvalid, wvalid, raddr, waddr, wdata,
        output readfin, writefin, readReady, writeReady, rdata
    );
endinterface

// File: rtl/ramsim_dpi.sv
// ramsim_dpi: cycle-accurate RAM model with independent fixed-latency read and write channels.
//   clk    rising-edge clock
//   rst_n  synchronous reset, ACTIVE-HIGH despite the name (kept for compatibility)
//   bus    ramsim_dpi_if.slave: rvalid/raddr, wvalid/waddr/wdata requests;
//          readReady/writeReady idle flags, readfin/writefin pulses, rdata
// Each channel runs IDLE -> BUSY -> DONE -> IDLE. Word i powers up holding the value i.
module ramsim_dpi #(
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    ramsim_dpi_if.slave bus
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned WCW = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e           r_rstate;
    state_e           w_rstate_d;
    state_e           r_wstate;
    state_e           w_wstate_d;
    logic [RCW-1:0]   r_rcnt;
    logic [RCW-1:0]   w_rcnt_d;
    logic [WCW-1:0]   r_wcnt;
    logic [WCW-1:0]   w_wcnt_d;
    logic [AW-1:0]    r_raddr;
    logic [AW-1:0]    r_waddr;
    logic [63:0]      r_wdata;
    logic [63:0]      r_rdata;
    logic [63:0]      r_mem [DEPTH];
    // A word never written reads as its own index; this avoids a power-up fill of r_mem.
    logic [DEPTH-1:0] r_written = '0;
    logic             w_rdone_edge;
    logic             w_wdone_edge;
    logic [63:0]      w_rword;
    logic             w_unused_addr;

    // Only the low AW address bits select a word; the rest wrap.
    assign w_unused_addr = ^{bus.raddr[63:AW], bus.waddr[63:AW]};

    // Last BUSY cycle: the coming edge enters DONE.
    assign w_rdone_edge = (r_rstate == StBusy) && (r_rcnt == '0);
    assign w_wdone_edge = (r_wstate == StBusy) && (r_wcnt == '0);

    assign w_rword = r_written[r_raddr] ? r_mem[r_raddr] : 64'(r_raddr);

    // ---------------- read channel ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rstate <= StIdle;
            r_rcnt   <= '0;
        end else begin
            r_rstate <= w_rstate_d;
            r_rcnt   <= w_rcnt_d;
        end
    end

    always_comb begin
        w_rstate_d = r_rstate;
        w_rcnt_d   = r_rcnt;
        unique case (r_rstate)
            StIdle: begin
                if (bus.rvalid) begin
                    w_rstate_d = StBusy;
                    w_rcnt_d   = RCW'(READ_LATENCY - 1);
                end
            end
            StBusy: begin
                if (r_rcnt == '0) begin
                    w_rstate_d = StDone;
                end else begin
                    w_rcnt_d = r_rcnt - RCW'(1);
                end
            end
            StDone:  w_rstate_d = StIdle;
            default: w_rstate_d = StIdle;
        endcase
    end

    always_comb begin
        bus.readReady = (r_rstate == StIdle);
        bus.readfin   = (r_rstate == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rdata <= '0;
        end else begin
            if ((r_rstate == StIdle) && bus.rvalid) begin
                r_raddr <= bus.raddr[AW-1:0];
            end
            // Same-edge write commit is non-blocking, so a colliding read sees old data.
            if (w_rdone_edge) begin
                r_rdata <= w_rword;
            end
        end
    end

    assign bus.rdata = r_rdata;

    // ---------------- write channel ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wstate <= StIdle;
            r_wcnt   <= '0;
        end else begin
            r_wstate <= w_wstate_d;
            r_wcnt   <= w_wcnt_d;
        end
    end

    always_comb begin
        w_wstate_d = r_wstate;
        w_wcnt_d   = r_wcnt;
        unique case (r_wstate)
            StIdle: begin
                if (bus.wvalid) begin
                    w_wstate_d = StBusy;
                    w_wcnt_d   = WCW'(WRITE_LATENCY - 1);
                end
            end
            StBusy: begin
                if (r_wcnt == '0) begin
                    w_wstate_d = StDone;
                end else begin
                    w_wcnt_d = r_wcnt - WCW'(1);
                end
            end
            StDone:  w_wstate_d = StIdle;
            default: w_wstate_d = StIdle;
        endcase
    end

    always_comb begin
        bus.writeReady = (r_wstate == StIdle);
        bus.writefin   = (r_wstate == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n && (r_wstate == StIdle) && bus.wvalid) begin
            r_waddr <= bus.waddr[AW-1:0];
            r_wdata <= bus.wdata;
        end
    end

    // Storage is untouched by reset; a reset edge also suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (!rst_n && w_wdone_edge) begin
            r_mem[r_waddr]     <= r_wdata;
            r_written[r_waddr] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ramsim_dpi.sv
// tb_ramsim_dpi: directed scenarios plus randomized traffic for ramsim_dpi, checked every cycle
// against a transaction-level model (due-edge arithmetic over a plain memory array).
module tb_ramsim_dpi;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned RL    = 4;
    localparam int unsigned WL    = 4;
    localparam int unsigned AW    = 10;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ramsim_dpi_if bus ();

    ramsim_dpi #(
        .DEPTH         (DEPTH),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    longint unsigned edge_n = 0;

    // Reference model state.
    logic [63:0]     m_mem [DEPTH];
    bit              rd_act = 1'b0;
    bit              wr_act = 1'b0;
    longint unsigned rd_due = 0;
    longint unsigned wr_due = 0;
    logic [AW-1:0]   rd_a = '0;
    logic [AW-1:0]   wr_a = '0;
    logic [63:0]     wr_d = '0;
    logic [63:0]     exp_rdata = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // One clock: drive inputs mid-cycle, advance the model at the edge, check #1 later.
    task automatic step(input bit rst, input bit rv, input logic [63:0] ra,
                        input bit wv, input logic [63:0] wa, input logic [63:0] wd);
        bit rd_idle;
        bit wr_idle;
        @(negedge clk);
        rst_n      = rst;
        bus.rvalid = rv;
        bus.raddr  = ra;
        bus.wvalid = wv;
        bus.waddr  = wa;
        bus.wdata  = wd;
        @(posedge clk);
        edge_n++;
        rd_idle = !rd_act;
        wr_idle = !wr_act;
        if (rst) begin
            rd_act    = 1'b0;
            wr_act    = 1'b0;
            exp_rdata = '0;
        end else begin
            // Read samples memory before this edge's write commit.
            if (rd_act && edge_n == rd_due) exp_rdata = m_mem[rd_a];
            if (wr_act && edge_n == wr_due) m_mem[wr_a] = wr_d;
            if (rd_act && edge_n == rd_due + 1) rd_act = 1'b0;
            if (wr_act && edge_n == wr_due + 1) wr_act = 1'b0;
            if (rd_idle && rv) begin
                rd_act = 1'b1;
                rd_due = edge_n + RL;
                rd_a   = ra[AW-1:0];
            end
            if (wr_idle && wv) begin
                wr_act = 1'b1;
                wr_due = edge_n + WL;
                wr_a   = wa[AW-1:0];
                wr_d   = wd;
            end
        end
        #1;
        check_eq("readfin",    64'(bus.readfin),    64'(rd_act && edge_n == rd_due));
        check_eq("writefin",   64'(bus.writefin),   64'(wr_act && edge_n == wr_due));
        check_eq("readReady",  64'(bus.readReady),  64'(!rd_act));
        check_eq("writeReady", 64'(bus.writeReady), 64'(!wr_act));
        check_eq("rdata",      bus.rdata,           exp_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic rd(input logic [63:0] a);
        step(1'b0, 1'b1, a, 1'b0, 64'd0, 64'd0);
        idle(6);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] wa;
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 64'(i);
        rst_n      = 1'b1;
        bus.rvalid = 1'b0;
        bus.wvalid = 1'b0;
        bus.raddr  = '0;
        bus.waddr  = '0;
        bus.wdata  = '0;

        // Reset with both valids high: nothing accepted, nothing committed.
        step(1'b1, 1'b1, 64'd5, 1'b1, 64'd5, 64'h1234);
        step(1'b1, 1'b1, 64'd5, 1'b1, 64'd5, 64'h1234);
        idle(1);
        rd(64'd5);
        check_eq("reset_no_commit", bus.rdata, 64'd5);

        // Basic read of the power-up pattern.
        rd(64'd13);
        idle(2);
        check_eq("rd13_hold", bus.rdata, 64'd13);

        // Write then read, including wrapped address.
        step(1'b0, 1'b0, 64'd0, 1'b1, 64'd7, 64'hDEADBEEF_CAFEF00D);
        idle(6);
        rd(64'd7);
        check_eq("rd7", bus.rdata, 64'hDEADBEEF_CAFEF00D);
        rd(64'd7 + 64'd1024);
        check_eq("rd7_wrap", bus.rdata, 64'hDEADBEEF_CAFEF00D);

        // Same-edge read/write collision returns the old word.
        step(1'b0, 1'b1, 64'd20, 1'b1, 64'd20, 64'h55);
        idle(6);
        check_eq("collide_old", bus.rdata, 64'd20);
        rd(64'd20);
        check_eq("collide_new", bus.rdata, 64'h55);

        // rvalid held high with a changing address.
        for (int k = 0; k < 18; k++) step(1'b0, 1'b1, 64'((k % 3) + 1), 1'b0, 64'd0, 64'd0);
        idle(6);

        // Reset two cycles after a write is accepted aborts it.
        step(1'b0, 1'b0, 64'd0, 1'b1, 64'd9, 64'hFF);
        idle(1);
        step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        idle(1);
        check_eq("ready_after_rst", 64'({bus.readReady, bus.writeReady}), 64'd3);
        rd(64'd9);
        check_eq("abort9", bus.rdata, 64'd9);
        idle(8);

        // Randomized traffic on a narrow address window to force collisions and wraps.
        for (int k = 0; k < 3000; k++) begin
            ra = {$urandom, 22'($urandom), 10'($urandom_range(15))};
            wa = {$urandom, 22'($urandom), 10'($urandom_range(15))};
            step($urandom_range(63) == 0, $urandom_range(9) < 6, ra,
                 $urandom_range(9) < 6, wa, {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
